// File: rtl/stream_rx_ctrl_if.sv
// Stream bundle between the DMA source, the receive controller and the core array.
// The slave modport is the controller's view; master is the surrounding environment.
interface stream_rx_ctrl_if #(
  parameter int DW = 32,
  parameter int IW = 4
);
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_last;
  logic          src_ready;
  logic          core_ready;
  logic          recv_v;
  logic [DW-1:0] recv_d;
  logic [IW-1:0] recv_i;
  logic          recv_last;

  modport slave (
    input  src_valid, src_data, src_last, core_ready,
    output src_ready, recv_v, recv_d, recv_i, recv_last
  );

  modport master (
    output src_valid, src_data, src_last, core_ready,
    input  src_ready, recv_v, recv_d, recv_i, recv_last
  );
endinterface

// File: rtl/stream_rx_ctrl.sv
// Receive-side AXI-Stream controller: skid-buffered DMA beats to the core array with round-robin index.
// Optional length check (recv_err port and beat counter) enabled by defining STREAM_RX_LEN_CHECK_EN.
module stream_rx_ctrl #(
  parameter int CORENUM = 16,
  parameter int DW      = 32,
  parameter int IW      = $clog2(CORENUM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  stream_rx_ctrl_if.slave        bus,
  output logic                   recv_done
`ifdef STREAM_RX_LEN_CHECK_EN
  ,
  output logic                   recv_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_src_ready;
  logic          r_out_v;
  logic [DW-1:0] r_out_d;
  logic [IW-1:0] r_out_i;
  logic          r_out_last;
  logic          r_skid_v;
  logic [DW-1:0] r_skid_d;
  logic          r_skid_last;
  logic [IW-1:0] r_idx;

  logic          w_in_xfer;
  logic          w_out_xfer;
  logic          w_out_free;
  logic          w_start_ok;
  logic          w_out_load;
  logic [DW-1:0] w_load_d;
  logic          w_load_last;
  logic          w_skid_load;
  logic          w_skid_v_nxt;
  logic [IW-1:0] w_idx_nxt;

  assign w_in_xfer  = bus.src_valid & r_src_ready;
  assign w_out_xfer = r_out_v & bus.core_ready;
  assign w_out_free = ~r_out_v | w_out_xfer;
  assign w_start_ok = (r_state == S_IDLE) & start;
  assign w_idx_nxt  = (r_idx == IW'(CORENUM - 1)) ? '0 : r_idx + IW'(1);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_in_xfer & bus.src_last) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (w_out_xfer & r_out_last) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // The skid entry always drains into the output register before a fresh beat can.
  always_comb begin
    w_out_load   = 1'b0;
    w_load_d     = r_skid_d;
    w_load_last  = r_skid_last;
    w_skid_v_nxt = r_skid_v;
    if (w_out_free) begin
      if (r_skid_v) begin
        w_out_load   = 1'b1;
        w_skid_v_nxt = w_in_xfer;
      end else if (w_in_xfer) begin
        w_out_load  = 1'b1;
        w_load_d    = bus.src_data;
        w_load_last = bus.src_last;
      end
    end else if (w_in_xfer) begin
      w_skid_v_nxt = 1'b1;
    end
  end

  assign w_skid_load = w_in_xfer & (r_skid_v | ~w_out_free);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_src_ready <= 1'b0;
      r_out_v     <= 1'b0;
      r_out_d     <= '0;
      r_out_i     <= '0;
      r_out_last  <= 1'b0;
      r_skid_v    <= 1'b0;
      r_skid_d    <= '0;
      r_skid_last <= 1'b0;
      r_idx       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_src_ready <= (w_state_nxt == S_ACTIVE) & ~w_skid_v_nxt;
      r_skid_v    <= w_skid_v_nxt;
      r_out_v     <= w_out_load | (r_out_v & ~w_out_xfer);
      if (w_skid_load) begin
        r_skid_d    <= bus.src_data;
        r_skid_last <= bus.src_last;
      end
      if (w_out_load) begin
        r_out_d    <= w_load_d;
        r_out_last <= w_load_last;
        r_out_i    <= r_idx;
        r_idx      <= w_idx_nxt;
      end
      if (w_start_ok) r_idx <= '0;
    end
  end

  assign bus.src_ready = r_src_ready;
  assign bus.recv_v    = r_out_v;
  assign bus.recv_d    = r_out_d;
  assign bus.recv_i    = r_out_i;
  assign bus.recv_last = r_out_last;
  assign recv_done     = (r_state == S_DONE);

`ifdef STREAM_RX_LEN_CHECK_EN
  logic [15:0] r_beat_cnt;
  logic        r_err;

  // The count is final once in DRAIN, so the flag is valid alongside recv_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_start_ok) begin
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_in_xfer && (r_beat_cnt != 16'hFFFF)) r_beat_cnt <= r_beat_cnt + 16'd1;
      if ((r_state == S_DRAIN) && (w_state_nxt == S_DONE) &&
          ((r_beat_cnt == 16'd0) || ((r_beat_cnt % 16'(CORENUM)) != 16'd0)))
        r_err <= 1'b1;
    end
  end

  assign recv_err = r_err;
`endif

endmodule

// File: tb/tb_stream_rx_ctrl.sv
// Self-checking bench: two controllers (CORENUM 16 and 4) run in lockstep on shared stimulus
// against a queue-based reference model of the stream.
module tb_stream_rx_ctrl;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          src_valid = 1'b0;
  logic          src_last = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          core_ready = 1'b0;
  logic          done16, done4;
`ifdef STREAM_RX_LEN_CHECK_EN
  logic          err16, err4;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stream_rx_ctrl_if #(.DW(DW), .IW(4)) if16 ();
  stream_rx_ctrl_if #(.DW(DW), .IW(2)) if4 ();

  assign if16.src_valid  = src_valid;
  assign if16.src_data   = src_data;
  assign if16.src_last   = src_last;
  assign if16.core_ready = core_ready;
  assign if4.src_valid   = src_valid;
  assign if4.src_data    = src_data;
  assign if4.src_last    = src_last;
  assign if4.core_ready  = core_ready;

  stream_rx_ctrl #(.CORENUM(16), .DW(DW), .IW(4)) dut16 (
    .clk(clk), .rst(rst), .start(start), .bus(if16.slave), .recv_done(done16)
`ifdef STREAM_RX_LEN_CHECK_EN
    , .recv_err(err16)
`endif
  );

  stream_rx_ctrl #(.CORENUM(4), .DW(DW), .IW(2)) dut4 (
    .clk(clk), .rst(rst), .start(start), .bus(if4.slave), .recv_done(done4)
`ifdef STREAM_RX_LEN_CHECK_EN
    , .recv_err(err4)
`endif
  );

  // Reference model: accepted-but-undelivered words, stream phase and delivery count.
  logic [DW:0]   sb[$];
  bit            busy, active, done_due, hold_chk;
  bit            e16, e4;
  int            n_out, beat_cnt, done_cnt;
  logic [DW-1:0] hold_d;
  logic [3:0]    hold_i16;
  logic [1:0]    hold_i4;
  logic          hold_last;

  task automatic model_clear();
    sb.delete();
    busy = 0; active = 0; done_due = 0; hold_chk = 0;
    e16 = 0; e4 = 0; n_out = 0; beat_cnt = 0;
  endtask

  // One clock: score the transfers due at the coming edge, then check post-edge outputs.
  task automatic advance();
    bit          in_x, out_x, in_done;
    logic [DW:0] w;
    in_done  = done_due;
    done_due = 0;
    in_x  = src_valid && (if16.src_ready === 1'b1);
    out_x = (if16.recv_v === 1'b1) && core_ready;
    n_cmp++;
    if ({if4.src_ready, if4.recv_v} !== {if16.src_ready, if16.recv_v}) begin
      n_bad++;
      $display("FAIL lockstep: corenum4 ready/valid=%b corenum16 ready/valid=%b",
               {if4.src_ready, if4.recv_v}, {if16.src_ready, if16.recv_v});
    end
    if (start && !busy) begin
      sb.delete();
      busy = 1; active = 1; n_out = 0; beat_cnt = 0; e16 = 0; e4 = 0;
    end
    if (in_x) begin
      sb.push_back({src_last, src_data});
      beat_cnt++;
      if (src_last) active = 0;
    end
    if (out_x) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL spurious_word: got d=%h with nothing outstanding", if16.recv_d);
      end else begin
        w = sb.pop_front();
        if ({if16.recv_last, if16.recv_d, if16.recv_i, if4.recv_d, if4.recv_i} !==
            {w[DW], w[DW-1:0], 4'(n_out % 16), w[DW-1:0], 2'(n_out % 4)}) begin
          n_bad++;
          $display("FAIL word%0d: got d=%h i16=%0d i4=%0d last=%b (d4=%h) expected d=%h i16=%0d i4=%0d last=%b",
                   n_out, if16.recv_d, if16.recv_i, if4.recv_i, if16.recv_last, if4.recv_d,
                   w[DW-1:0], n_out % 16, n_out % 4, w[DW]);
        end
        n_out++;
        if (w[DW]) begin
          done_due = 1;
          e16 = (beat_cnt == 0) || (beat_cnt % 16 != 0);
          e4  = (beat_cnt == 0) || (beat_cnt % 4 != 0);
        end
      end
    end
    hold_chk  = (if16.recv_v === 1'b1) && !core_ready;
    hold_d    = if16.recv_d;
    hold_i16  = if16.recv_i;
    hold_i4   = if4.recv_i;
    hold_last = if16.recv_last;
    if (in_done) busy = 0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({done16, done4} !== {done_due, done_due}) begin
      n_bad++;
      $display("FAIL recv_done: got %b/%b expected %b", done16, done4, done_due);
    end
    if (done_due) done_cnt++;
    if (!active) begin
      n_cmp++;
      if (if16.src_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL ready_outside_active: got %b expected 0", if16.src_ready);
      end
    end
    n_cmp++;
    if (sb.size() > 2) begin
      n_bad++;
      $display("FAIL occupancy: got %0d words buffered expected at most 2", sb.size());
    end
    if (hold_chk) begin
      n_cmp++;
      if ({if16.recv_v, if16.recv_d, if16.recv_i, if4.recv_i, if16.recv_last} !==
          {1'b1, hold_d, hold_i16, hold_i4, hold_last}) begin
        n_bad++;
        $display("FAIL hold_stable: got v=%b d=%h i=%0d last=%b expected v=1 d=%h i=%0d last=%b",
                 if16.recv_v, if16.recv_d, if16.recv_i, if16.recv_last, hold_d, hold_i16, hold_last);
      end
    end
`ifdef STREAM_RX_LEN_CHECK_EN
    n_cmp++;
    if ({err16, err4} !== {e16, e4}) begin
      n_bad++;
      $display("FAIL recv_err: got %b/%b expected %b/%b", err16, err4, e16, e4);
    end
`endif
  endtask

  task automatic do_start();
    start = 1'b1;
    advance();
    start = 1'b0;
    n_cmp++;
    if (if16.src_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_start: got %b expected 1", if16.src_ready);
    end
  endtask

  // Drives one stream of n beats; valid is held until accepted, gaps/stalls are random.
  task automatic run_stream(input int n, input int gap_pct, input int cr_pct,
                            input int start_at, input bit rnd_data, input logic [DW-1:0] base);
    int  b;
    bit  acc, finished;
    int  d0;
    d0 = done_cnt;
    finished = 0;
    core_ready = 1'b1;
    do_start();
    b = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!src_valid && b < n && $urandom_range(99) >= gap_pct) begin
        src_valid = 1'b1;
        src_data  = rnd_data ? $urandom : base + DW'(b);
        src_last  = (b == n - 1);
      end
      core_ready = ($urandom_range(99) >= cr_pct);
      start      = (cyc == start_at);
      acc = src_valid && (if16.src_ready === 1'b1);
      advance();
      if (acc) begin
        b++;
        src_valid = 1'b0;
        src_last  = 1'b0;
      end
      if (done_cnt != d0) begin
        finished = 1;
        break;
      end
    end
    start = 1'b0;
    src_valid = 1'b0;
    src_last = 1'b0;
    n_cmp++;
    if (!finished) begin
      n_bad++;
      $display("FAIL stream_timeout: got no recv_done after %0d beats sent, expected one", b);
    end
    advance();
    n_cmp++;
    if (if16.src_ready !== 1'b0 || done_cnt != d0 + 1) begin
      n_bad++;
      $display("FAIL stream_end: got ready=%b dones=%0d expected ready=0 dones=%0d",
               if16.src_ready, done_cnt - d0, 1);
    end
  endtask

  task automatic test_reset();
    model_clear();
    #3 rst = 1'b0;
    #1;
    n_cmp++;
    if ({if16.src_ready, if16.recv_v, if16.recv_d, if16.recv_i, if16.recv_last, done16,
         if4.src_ready, if4.recv_v, if4.recv_d, if4.recv_i, if4.recv_last, done4} !== '0) begin
      n_bad++;
      $display("FAIL reset_values: got ready=%b v=%b d=%h i=%0d last=%b done=%b expected all 0",
               if16.src_ready, if16.recv_v, if16.recv_d, if16.recv_i, if16.recv_last, done16);
    end
`ifdef STREAM_RX_LEN_CHECK_EN
    n_cmp++;
    if ({err16, err4} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_err: got %b%b expected 00", err16, err4);
    end
`endif
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    advance();
  endtask

  task automatic test_basic();
    run_stream(16, 0, 0, -1, 1'b0, 32'h100);
    n_cmp++;
    if (n_out != 16) begin
      n_bad++;
      $display("FAIL basic_count: got %0d words expected 16", n_out);
    end
  endtask

  task automatic test_corenum4();
    run_stream(10, 0, 0, -1, 1'b0, 32'hA00);
    n_cmp++;
    if (n_out != 10) begin
      n_bad++;
      $display("FAIL corenum4_count: got %0d words expected 10", n_out);
    end
  endtask

  task automatic test_backpressure();
    int b;
    bit acc;
    int d0;
    d0 = done_cnt;
    core_ready = 1'b1;
    do_start();
    b = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      src_valid  = (b < 12);
      src_data   = 32'h200 + DW'(b);
      src_last   = (b == 11);
      core_ready = !(cyc >= 6 && cyc < 9);
      acc = src_valid && (if16.src_ready === 1'b1);
      advance();
      if (acc) b++;
      if (cyc == 0) begin
        n_cmp++;
        if (if16.recv_v !== 1'b1 || if16.recv_d !== 32'h200) begin
          n_bad++;
          $display("FAIL first_latency: got v=%b d=%h expected v=1 d=00000200", if16.recv_v, if16.recv_d);
        end
      end
      if (cyc == 6 || cyc == 8) begin
        n_cmp++;
        if (if16.src_ready !== 1'b0 || sb.size() != 2) begin
          n_bad++;
          $display("FAIL skid_full@%0d: got ready=%b buffered=%0d expected ready=0 buffered=2",
                   cyc, if16.src_ready, sb.size());
        end
      end
      if (cyc == 9) begin
        n_cmp++;
        if (if16.src_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL ready_return: got %b expected 1", if16.src_ready);
        end
      end
      if (done_cnt != d0) break;
    end
    src_valid = 1'b0;
    src_last = 1'b0;
    advance();
    n_cmp++;
    if (done_cnt != d0 + 1 || n_out != 12) begin
      n_bad++;
      $display("FAIL backpressure_end: got dones=%0d words=%0d expected dones=1 words=12",
               done_cnt - d0, n_out);
    end
  endtask

  task automatic test_random();
    run_stream(64, 30, 30, -1, 1'b1, '0);
    n_cmp++;
    if (n_out != 64) begin
      n_bad++;
      $display("FAIL random_count: got %0d words expected 64", n_out);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_cnt;
    do_start();
    for (int cyc = 0; cyc < 6; cyc++) begin
      src_valid  = 1'b1;
      src_data   = 32'hDEAD0000 + DW'(cyc);
      src_last   = 1'b0;
      core_ready = (cyc < 3);
      advance();
    end
    #3 rst = 1'b0;
    #1;
    n_cmp++;
    if ({if16.src_ready, if16.recv_v, if16.recv_d, if16.recv_i, if16.recv_last, done16} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got ready=%b v=%b d=%h i=%0d last=%b done=%b expected all 0",
               if16.src_ready, if16.recv_v, if16.recv_d, if16.recv_i, if16.recv_last, done16);
    end
    src_valid = 1'b0;
    core_ready = 1'b0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    advance();
    advance();
    n_cmp++;
    if (done_cnt != d0) begin
      n_bad++;
      $display("FAIL aborted_done: got %0d dones expected 0", done_cnt - d0);
    end
    run_stream(8, 10, 10, -1, 1'b0, 32'h300);
  endtask

  task automatic test_start_ignored();
    run_stream(20, 10, 10, 5, 1'b1, '0);
    n_cmp++;
    if (n_out != 20) begin
      n_bad++;
      $display("FAIL start_ignored_count: got %0d words expected 20", n_out);
    end
  endtask

  initial begin
    done_cnt = 0;
    test_reset();
    test_basic();
    test_corenum4();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
